// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: hands out sequential tags, writes out-of-order responses into
// the reorder RAM and drains it in tag order. Optional response checking: ROB_CTRL_ERR_CHK_EN.
module rob_ctrl #(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_req,
   output logic              alloc_gnt,
   output logic [ADDR_W-1:0] alloc_tag,
   input  logic              rsp_valid,
   input  logic [ADDR_W-1:0] rsp_tag,
   input  logic [511:0]      rsp_data,
   output logic              rob_wr_en,
   output logic [15:0]       rob_wr_addr,
   output logic [511:0]      rob_wr_data,
   output logic [15:0]       rob_rd_addr,
   input  logic [511:0]      rob_rd_data,
   output logic              out_valid,
   output logic [511:0]      out_data,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int FIFO_D = RD_LAT + 1;
   localparam int FW     = $clog2(FIFO_D + 1);
   localparam int FI     = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
   localparam logic [FW-1:0]   OCC_ONE = FW'(1);
   localparam logic [FW-1:0]   CREDIT_MAX = FW'(FIFO_D);
   localparam logic [FI-1:0]   IDX_ONE = FI'(1);
   localparam logic [FI-1:0]   IDX_LAST = FI'(FIFO_D - 1);

   logic [ADDR_W:0]   tail_q;
   logic [ADDR_W:0]   head_q;
   logic [DEPTH-1:0]  valid_q;
   logic [RD_LAT-1:0] rd_pipe_q;
   logic [511:0]      fifo_mem [FIFO_D];
   logic [FI-1:0]     fifo_wr_q;
   logic [FI-1:0]     fifo_rd_q;
   logic [FW-1:0]     fifo_occ_q;
   logic [FW-1:0]     in_flight;
   logic [ADDR_W-1:0] head_idx;
   logic              full;
   logic              issue;
   logic              pipe_exit;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   function automatic logic [FI-1:0] fifo_next(input logic [FI-1:0] idx);
      return (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
   endfunction

   assign head_idx    = head_q[ADDR_W-1:0];
   assign count       = tail_q - head_q;
   assign full        = count[ADDR_W];
   assign alloc_gnt   = alloc_req && !full;
   assign alloc_tag   = tail_q[ADDR_W-1:0];
   assign rob_rd_addr = 16'(head_idx);

   // Reads already issued but whose data has not yet reached the output FIFO
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + FW'(rd_pipe_q[i]);
      end
   end

   // A read is only launched when the FIFO is guaranteed to have room for its data
   assign issue      = valid_q[head_idx] && ((in_flight + fifo_occ_q) < CREDIT_MAX);
   assign pipe_exit  = rd_pipe_q[RD_LAT-1];
   assign fifo_empty = (fifo_occ_q == '0);
   assign out_valid  = !fifo_empty || pipe_exit;
   assign fifo_pop   = !fifo_empty && out_ready;
   assign fifo_push  = pipe_exit && !(fifo_empty && out_ready);

   // Empty FIFO lets the returning RAM word straight through to the consumer
   always_comb begin
      out_data = '0;
      if (!fifo_empty) begin
         out_data = fifo_mem[fifo_rd_q];
      end else if (pipe_exit) begin
         out_data = rob_rd_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tail_q <= '0;
         head_q <= '0;
      end else begin
         if (alloc_gnt) begin
            tail_q <= tail_q + PTR_ONE;
         end
         if (issue) begin
            head_q <= head_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rob_wr_en   <= 1'b0;
         rob_wr_addr <= '0;
         rob_wr_data <= '0;
      end else begin
         rob_wr_en   <= rsp_valid;
         rob_wr_addr <= 16'(rsp_tag);
         rob_wr_data <= rsp_data;
      end
   end

   // Valid is set only once the RAM write has landed, so a drain read never races it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         if (issue) begin
            valid_q[head_idx] <= 1'b0;
         end
         if (rob_wr_en) begin
            valid_q[rob_wr_addr[ADDR_W-1:0]] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_wr_q  <= '0;
         fifo_rd_q  <= '0;
         fifo_occ_q <= '0;
      end else begin
         if (fifo_push) begin
            fifo_wr_q <= fifo_next(fifo_wr_q);
         end
         if (fifo_pop) begin
            fifo_rd_q <= fifo_next(fifo_rd_q);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_occ_q <= fifo_occ_q + OCC_ONE;
            2'b01:   fifo_occ_q <= fifo_occ_q - OCC_ONE;
            default: fifo_occ_q <= fifo_occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[fifo_wr_q] <= rob_rd_data;
      end
   end

`ifdef ROB_CTRL_ERR_CHK_EN
   logic [ADDR_W-1:0] rsp_off;
   logic              rsp_out_of_range;
   logic              rsp_dup;

   // A tag is live when its distance from head is below the number of outstanding tags
   assign rsp_off          = rsp_tag - head_idx;
   assign rsp_out_of_range = ({1'b0, rsp_off} >= count);
   assign rsp_dup          = valid_q[rsp_tag] ||
                             (rob_wr_en && (rob_wr_addr[ADDR_W-1:0] == rsp_tag));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (rsp_valid && (rsp_out_of_range || rsp_dup)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
